// File: rtl/calculator_div.sv
// Key-driven signed divider: dividend, divide key, divisor, equals; restoring division on magnitudes.
// Define CALC_DIV_OVF_SAT_EN to saturate -2^(N-1) / -1 to the largest positive value and flag overflow.
module calculator_div #(
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [N-1:0] number_in,
    input  logic                load,
    input  logic                div,
    input  logic                equal,
    output logic signed [N-1:0] quotient,
    output logic signed [N-1:0] remainder,
    output logic                ready,
    output logic                div_by_zero,
    output logic                overflow
);

    typedef enum logic [2:0] {
        S_A,
        S_OP,
        S_B,
        S_EQ,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    localparam int CW = $clog2(N + 1);
    localparam logic signed [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};
    localparam logic signed [N-1:0] MAX_VAL = {1'b0, {(N-1){1'b1}}};

    state_t              state_q, state_d;
    logic signed [N-1:0] dividend_q, dividend_d;
    logic signed [N-1:0] divisor_q, divisor_d;
    logic [N:0]          rem_q, rem_d;
    logic [N-1:0]        quo_q, quo_d;
    logic [N:0]          dsr_mag_q, dsr_mag_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                q_neg_q, q_neg_d;
    logic                r_neg_q, r_neg_d;
    logic                dbz_pend_q, dbz_pend_d;
    logic                ovf_pend_q, ovf_pend_d;
    logic signed [N-1:0] quotient_q, quotient_d;
    logic signed [N-1:0] remainder_q, remainder_d;
    logic                ready_q, ready_d;
    logic                dbz_q, dbz_d;
    logic                ovf_q, ovf_d;

    logic [N:0]   dvd_ext, dsr_ext, dvd_mag, dsr_mag;
    logic [N:0]   shifted, diff, r_full;
    logic [N-1:0] q_full;
    logic         fits;
    logic         min_by_neg_one;

    always_comb begin
        dvd_ext = {dividend_q[N-1], dividend_q};
        dsr_ext = {divisor_q[N-1], divisor_q};
        // N+1 bits so that the magnitude of -2^(N-1) is representable
        dvd_mag = dividend_q[N-1] ? -dvd_ext : dvd_ext;
        dsr_mag = divisor_q[N-1] ? -dsr_ext : dsr_ext;

        shifted = {rem_q[N-1:0], quo_q[N-1]};
        diff    = shifted - dsr_mag_q;
        fits    = (shifted >= dsr_mag_q);

        q_full  = q_neg_q ? -quo_q : quo_q;
        r_full  = r_neg_q ? -rem_q : rem_q;

        min_by_neg_one = (dividend_q == MIN_VAL) && (divisor_q == '1);
    end

    always_comb begin
        state_d     = state_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_mag_d   = dsr_mag_q;
        cnt_d       = cnt_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        dbz_pend_d  = dbz_pend_q;
        ovf_pend_d  = ovf_pend_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        ready_d     = ready_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        case (state_q)
            S_A: begin
                if (load) begin
                    dividend_d = number_in;
                    state_d    = S_OP;
                end
            end
            S_OP: begin
                if (div) begin
                    state_d = S_B;
                end else if (load) begin
                    dividend_d = number_in;
                end
            end
            S_B: begin
                if (load) begin
                    divisor_d = number_in;
                    state_d   = S_EQ;
                end
            end
            S_EQ: begin
                if (equal) begin
                    ovf_pend_d = 1'b0;
                    if (divisor_q == '0) begin
                        quo_d      = '1;
                        rem_d      = dvd_ext;
                        dbz_pend_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        // partial remainder starts from the magnitude's guard bit
                        rem_d      = {{N{1'b0}}, dvd_mag[N]};
                        quo_d      = dvd_mag[N-1:0];
                        dsr_mag_d  = dsr_mag;
                        q_neg_d    = dividend_q[N-1] ^ divisor_q[N-1];
                        r_neg_d    = dividend_q[N-1];
                        cnt_d      = '0;
                        dbz_pend_d = 1'b0;
                        state_d    = S_CALC;
                    end
                end else if (load) begin
                    divisor_d = number_in;
                end
            end
            S_CALC: begin
                rem_d = fits ? diff : shifted;
                quo_d = {quo_q[N-2:0], fits};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                quo_d = q_full;
                rem_d = r_full;
`ifdef CALC_DIV_OVF_SAT_EN
                if (min_by_neg_one) begin
                    quo_d      = MAX_VAL;
                    rem_d      = '0;
                    ovf_pend_d = 1'b1;
                end
`else
                // -2^(N-1) / -1 wraps back to -2^(N-1) through the negation
                if (min_by_neg_one) begin
                    ovf_pend_d = 1'b0;
                end
`endif
                state_d = S_DONE;
            end
            S_DONE: begin
                if (load) begin
                    ready_d    = 1'b0;
                    dbz_d      = 1'b0;
                    ovf_d      = 1'b0;
                    dividend_d = number_in;
                    state_d    = S_OP;
                end else if (!ready_q) begin
                    ready_d     = 1'b1;
                    quotient_d  = quo_q;
                    remainder_d = rem_q[N-1:0];
                    dbz_d       = dbz_pend_q;
                    ovf_d       = ovf_pend_q;
                end
            end
            default: begin
                state_d = S_A;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_A;
            dividend_q  <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_mag_q   <= '0;
            cnt_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dbz_pend_q  <= 1'b0;
            ovf_pend_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            ready_q     <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dsr_mag_q   <= dsr_mag_d;
            cnt_q       <= cnt_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            dbz_pend_q  <= dbz_pend_d;
            ovf_pend_q  <= ovf_pend_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            ready_q     <= ready_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign ready       = ready_q;
    assign div_by_zero = dbz_q;
`ifdef CALC_DIV_OVF_SAT_EN
    assign overflow    = ovf_q;
`else
    assign overflow    = 1'b0;
`endif

endmodule

// File: tb/tb_calculator_div.sv
// Bench for calculator_div: vector table plus hand-written sequences for reset and strobe corners.
`timescale 1ns/1ps
module tb_calculator_div;

    localparam int N = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic signed [N-1:0] number_in;
    logic                load, div, equal;
    logic signed [N-1:0] quotient, remainder;
    logic                ready, div_by_zero, overflow;

    always #5 clk = ~clk;

    calculator_div #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .number_in  (number_in),
        .load       (load),
        .div        (div),
        .equal      (equal),
        .quotient   (quotient),
        .remainder  (remainder),
        .ready      (ready),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    typedef struct {
        logic signed [N-1:0] a;
        logic signed [N-1:0] b;
        logic signed [N-1:0] q;
        logic signed [N-1:0] r;
        logic                dbz;
        logic                ovf;
        int                  lat;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[13];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input int a, b, q, r, dbz, ovf, lat);
        vec_t v;
        v.a   = N'(a);
        v.b   = N'(b);
        v.q   = N'(q);
        v.r   = N'(r);
        v.dbz = dbz[0];
        v.ovf = ovf[0];
        v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic l, input logic d, input logic e, input logic signed [N-1:0] v);
        load      = l;
        div       = d;
        equal     = e;
        number_in = v;
        tick();
        load  = 1'b0;
        div   = 1'b0;
        equal = 1'b0;
    endtask

    task automatic start_op(input logic signed [N-1:0] a, input logic signed [N-1:0] b);
        strobe(1'b1, 1'b0, 1'b0, a);
        strobe(1'b0, 1'b1, 1'b0, '0);
        strobe(1'b1, 1'b0, 1'b0, b);
    endtask

    task automatic fire(input vec_t v);
        sb.push_back(v);
        strobe(1'b0, 1'b0, 1'b1, '0);
    endtask

    // Waits for ready after equal was sampled; optionally throws strobes at the busy divider.
    task automatic wait_result(input bit noise);
        vec_t e;
        bit   seen = 1'b0;
        int   lat  = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            if (noise && k >= 2 && k <= 4) begin
                load      = 1'b1;
                div       = (k == 3);
                equal     = 1'b1;
                number_in = N'($urandom);
            end else begin
                load  = 1'b0;
                div   = 1'b0;
                equal = 1'b0;
            end
            tick();
            if (ready) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        load  = 1'b0;
        div   = 1'b0;
        equal = 1'b0;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got result with no expectation queued");
            return;
        end
        e = sb.pop_front();
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout %0d/%0d: got no ready required ready within 40 cycles", e.a, e.b);
            return;
        end
        $display("div %0d / %0d -> q=%0d r=%0d dbz=%0d ovf=%0d lat=%0d", e.a, e.b,
                 quotient, remainder, div_by_zero, overflow, lat);
        chk("latency", lat, e.lat);
        chk("quotient", int'(quotient), int'(e.q));
        chk("remainder", int'(remainder), int'(e.r));
        chk("div_by_zero", int'(div_by_zero), int'(e.dbz));
        chk("overflow", int'(overflow), int'(e.ovf));
    endtask

    initial begin
        tbl[0]  = mk( 100,    7,  14,    2, 0, 0, N + 2);
        tbl[1]  = mk(-100,    7, -14,   -2, 0, 0, N + 2);
        tbl[2]  = mk( 100,   -7, -14,    2, 0, 0, N + 2);
        tbl[3]  = mk(-100,   -7,  14,   -2, 0, 0, N + 2);
        tbl[4]  = mk(   5,    0,  -1,    5, 1, 0, 1);
`ifdef CALC_DIV_OVF_SAT_EN
        tbl[5]  = mk(-128,   -1, 127,    0, 0, 1, N + 2);
`else
        tbl[5]  = mk(-128,   -1, -128,   0, 0, 0, N + 2);
`endif
        tbl[6]  = mk(-128,    1, -128,   0, 0, 0, N + 2);
        tbl[7]  = mk( 127, -128,   0,  127, 0, 0, N + 2);
        tbl[8]  = mk(-128, -128,   1,    0, 0, 0, N + 2);
        tbl[9]  = mk(   0,    5,   0,    0, 0, 0, N + 2);
        tbl[10] = mk(  -7,    2,  -3,   -1, 0, 0, N + 2);
        tbl[11] = mk(-128,    7, -18,   -2, 0, 0, N + 2);
        tbl[12] = mk(-128,    0,  -1, -128, 1, 0, 1);

        rst       = 1'b0;
        load      = 1'b0;
        div       = 1'b0;
        equal     = 1'b0;
        number_in = '0;
        repeat (3) tick();
        chk("reset_quotient", int'(quotient), 0);
        chk("reset_remainder", int'(remainder), 0);
        chk("reset_ready", int'(ready), 0);
        chk("reset_dbz", int'(div_by_zero), 0);
        chk("reset_ovf", int'(overflow), 0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) begin
            start_op(tbl[i].a, tbl[i].b);
            fire(tbl[i]);
            wait_result(i % 2 == 1);
        end

        // Result holds in S_DONE; a load clears ready and flags.
        start_op(100, 7);
        fire(mk(100, 7, 14, 2, 0, 0, N + 2));
        wait_result(1'b0);
        repeat (3) tick();
        chk("hold_ready", int'(ready), 1);
        chk("hold_quotient", int'(quotient), 14);
        strobe(1'b1, 1'b0, 1'b0, 5);
        chk("load_clears_ready", int'(ready), 0);
        strobe(1'b0, 1'b1, 1'b0, '0);
        strobe(1'b1, 1'b0, 1'b0, 0);
        fire(mk(5, 0, -1, 5, 1, 0, 1));
        wait_result(1'b0);
        strobe(1'b1, 1'b0, 1'b0, 9);
        chk("load_clears_dbz", int'(div_by_zero), 0);
        chk("load_clears_ready2", int'(ready), 0);

        // Operand replacement in S_OP and S_EQ.
        strobe(1'b1, 1'b0, 1'b0, 100);
        strobe(1'b0, 1'b1, 1'b0, '0);
        strobe(1'b1, 1'b0, 1'b0, 3);
        strobe(1'b1, 1'b0, 1'b0, 7);
        fire(mk(100, 7, 14, 2, 0, 0, N + 2));
        wait_result(1'b0);

        // Load together with equal: equal wins, divisor kept.
        start_op(-100, 7);
        sb.push_back(mk(-100, 7, -14, -2, 0, 0, N + 2));
        strobe(1'b1, 1'b0, 1'b1, 99);
        wait_result(1'b1);

        // Asynchronous reset in the middle of the division.
        start_op(100, 7);
        strobe(1'b0, 1'b0, 1'b1, '0);
        repeat (3) tick();
        #2 rst = 1'b0;
        #1;
        chk("midreset_quotient", int'(quotient), 0);
        chk("midreset_remainder", int'(remainder), 0);
        chk("midreset_ready", int'(ready), 0);
        chk("midreset_dbz", int'(div_by_zero), 0);
        chk("midreset_ovf", int'(overflow), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        strobe(1'b0, 1'b0, 1'b1, '0);
        strobe(1'b0, 1'b1, 1'b0, '0);
        repeat (12) tick();
        chk("no_resume_ready", int'(ready), 0);
        start_op(9, 3);
        fire(mk(9, 3, 3, 0, 0, 0, N + 2));
        wait_result(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
